// File: rtl/match_referee.sv
`default_nettype none
// ============================================================================
// Module   : match_referee
// Purpose  : Round/match controller for the two-player fighting core. It runs
//            the round timer, awards round points and declares the winner.
//            Optional sudden-death overtime: MATCH_REFEREE_SUDDEN_DEATH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module match_referee #(
    parameter  int ROUND_TICKS   = 1024,
    parameter  int PAUSE_TICKS   = 16,
    parameter  int ROUNDS_TO_WIN = 2,
    localparam int TW            = $clog2(ROUND_TICKS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    right_player_health_in,
    input  logic [1:0]    left_player_health_in,
    output logic          round_restart,
    output logic          round_active,
    output logic [TW-1:0] time_left,
    output logic [1:0]    right_score,
    output logic [1:0]    left_score,
    output logic          round_done,
    output logic [1:0]    round_winner,
    output logic          match_over,
    output logic [1:0]    match_winner
);

    localparam int PW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

    localparam logic [TW-1:0] c_round_ticks = TW'(ROUND_TICKS);
    localparam logic [TW-1:0] c_last_tick   = TW'(1);
    localparam logic [PW-1:0] c_pause_load  = PW'(PAUSE_TICKS - 1);
    localparam logic [1:0]    c_win_score   = 2'(ROUNDS_TO_WIN);
    localparam logic [1:0]    c_none        = 2'b00;
    localparam logic [1:0]    c_right       = 2'b01;
    localparam logic [1:0]    c_left        = 2'b10;
    localparam logic [1:0]    c_draw        = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RESTART    = 3'd1,
        S_FIGHT      = 3'd2,
        S_ROUND_END  = 3'd3,
        S_MATCH_OVER = 3'd4
`ifdef MATCH_REFEREE_SUDDEN_DEATH_EN
        ,
        S_SUDDEN     = 3'd5
`endif
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_decide;
    logic            w_clear;
    logic [1:0]      w_winner;
    logic [1:0]      w_higher;
    logic            w_right_ko;
    logic            w_left_ko;
    logic            w_first_fight;

    logic            r_round_restart;
    logic            r_round_active;
    logic [TW-1:0]   r_time_left;
    logic [1:0]      r_right_score;
    logic [1:0]      r_left_score;
    logic            r_round_done;
    logic [1:0]      r_round_winner;
    logic            r_match_over;
    logic [1:0]      r_match_winner;
    logic [PW-1:0]   r_pause;

    assign w_right_ko    = (right_player_health_in == 2'd0);
    assign w_left_ko     = (left_player_health_in == 2'd0);
    // The timer still holds its load value only during the first FIGHT cycle,
    // while the freshly reset core's health is not yet trustworthy.
    assign w_first_fight = (r_time_left == c_round_ticks);
    assign w_higher      = (right_player_health_in > left_player_health_in) ? c_right :
                           (left_player_health_in > right_player_health_in) ? c_left  : c_draw;

    always_comb begin
        w_next   = r_state;
        w_decide = 1'b0;
        w_clear  = 1'b0;
        w_winner = c_none;
        case (r_state)
            S_IDLE, S_MATCH_OVER: begin
                if (start) begin
                    w_next  = S_RESTART;
                    w_clear = 1'b1;
                end
            end
            S_RESTART: w_next = S_FIGHT;
            S_FIGHT: begin
                if (!w_first_fight && (w_right_ko || w_left_ko)) begin
                    w_decide = 1'b1;
                    w_winner = (w_right_ko && w_left_ko) ? c_draw :
                               (w_right_ko ? c_left : c_right);
                end else if (r_time_left == c_last_tick) begin
`ifdef MATCH_REFEREE_SUDDEN_DEATH_EN
                    if (w_higher == c_draw) begin
                        w_next = S_SUDDEN;
                    end else begin
                        w_decide = 1'b1;
                        w_winner = w_higher;
                    end
`else
                    w_decide = 1'b1;
                    w_winner = w_higher;
`endif
                end
            end
`ifdef MATCH_REFEREE_SUDDEN_DEATH_EN
            S_SUDDEN: begin
                if (w_right_ko && w_left_ko) begin
                    w_decide = 1'b1;
                    w_winner = c_draw;
                end else if (w_higher != c_draw) begin
                    w_decide = 1'b1;
                    w_winner = w_higher;
                end
            end
`endif
            S_ROUND_END: begin
                if (r_pause == '0) begin
                    w_next = ((r_right_score == c_win_score) || (r_left_score == c_win_score)) ?
                             S_MATCH_OVER : S_RESTART;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_decide) begin
            w_next = S_ROUND_END;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_round_restart <= 1'b0;
            r_round_active  <= 1'b0;
            r_time_left     <= '0;
            r_right_score   <= 2'd0;
            r_left_score    <= 2'd0;
            r_round_done    <= 1'b0;
            r_round_winner  <= c_none;
            r_match_over    <= 1'b0;
            r_match_winner  <= c_none;
            r_pause         <= '0;
        end else begin
            r_state         <= w_next;
            r_round_restart <= (w_next == S_RESTART);
`ifdef MATCH_REFEREE_SUDDEN_DEATH_EN
            r_round_active  <= (w_next == S_FIGHT) || (w_next == S_SUDDEN);
`else
            r_round_active  <= (w_next == S_FIGHT);
`endif
            r_match_over    <= (w_next == S_MATCH_OVER);
            r_round_done    <= w_decide;

            if (r_state == S_RESTART) begin
                r_time_left <= c_round_ticks;
            end else if ((r_state == S_FIGHT) && (r_time_left != '0)) begin
                r_time_left <= r_time_left - c_last_tick;
            end

            if (w_decide) begin
                r_round_winner <= w_winner;
                r_pause        <= c_pause_load;
                if ((w_winner == c_right) && (r_right_score != 2'd3)) begin
                    r_right_score <= r_right_score + 2'd1;
                end
                if ((w_winner == c_left) && (r_left_score != 2'd3)) begin
                    r_left_score <= r_left_score + 2'd1;
                end
            end else if ((r_state == S_ROUND_END) && (r_pause != '0)) begin
                r_pause <= r_pause - PW'(1);
            end

            if (w_clear) begin
                r_right_score  <= 2'd0;
                r_left_score   <= 2'd0;
                r_round_winner <= c_none;
                r_match_winner <= c_none;
            end else if ((r_state == S_ROUND_END) && (w_next == S_MATCH_OVER)) begin
                r_match_winner <= (r_right_score == c_win_score) ? c_right : c_left;
            end
        end
    end

    assign round_restart = r_round_restart;
    assign round_active  = r_round_active;
    assign time_left     = r_time_left;
    assign right_score   = r_right_score;
    assign left_score    = r_left_score;
    assign round_done    = r_round_done;
    assign round_winner  = r_round_winner;
    assign match_over    = r_match_over;
    assign match_winner  = r_match_winner;

endmodule
`default_nettype wire
